cpu_div_cell: RTL and testbench
===============================

Name: cpu_div_cell

Overview:
- Iterative radix-2 integer divider that complements the CPU multiply cell in the custom-instruction/ALU datapath.
- Accepts a dividend/divisor pair on a start strobe and computes one quotient bit per cycle (non-restoring shift-subtract).
- Returns quotient and remainder with a one-cycle done pulse.
- Supports signed and unsigned operation, with defined divide-by-zero and signed-overflow results.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..32.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous active-high reset
- A_div_start  input  1  start strobe, sampled only when not busy
- A_div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- A_div_src1  input  WIDTH  dividend, sampled with start
- A_div_src2  input  WIDTH  divisor, sampled with start
- A_div_busy  output  1  high while an operation is in flight
- A_div_done  output  1  one-cycle pulse, results valid
- A_div_quotient  output  WIDTH  quotient, held until next accepted start
- A_div_remainder  output  WIDTH  remainder, held until next accepted start
- A_div_by_zero  output  1  divisor was zero for the last result, held with results

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
  - Reset forces state IDLE.
  - busy=0, done=0, quotient=0, remainder=0, by_zero=0; internal counter/accumulators are cleared.
- States: IDLE, RUN, FIX, DONE.
- IDLE or DONE with start=1:
  - Latch the signed flag.
  - Take the magnitudes |src1| and |src2|; when signed=0, operands are used as-is.
  - Record the quotient sign (src1[MSB]^src2[MSB])&signed and the remainder sign src1[MSB]&signed.
  - Record by_zero = (src2==0).
  - Clear the partial remainder (WIDTH+1 bits) and counter; go to RUN, busy=1.
- RUN, WIDTH cycles:
  - Each cycle shift {partial remainder, dividend} left by one.
  - If the partial remainder is non-negative, subtract the divisor magnitude; otherwise add it.
  - The new quotient LSB is the inverted sign of the result.
  - The counter increments; after count WIDTH-1, go to FIX.
- FIX, 1 cycle:
  - If the partial remainder is negative, add the divisor back.
  - Apply the sign corrections (negate the quotient if its sign is set; negate the remainder if the dividend was negative).
  - Apply the special cases below, register the outputs, go to DONE.
- DONE, 1 cycle: done=1, busy=0; go to IDLE unless start=1, in which case the start is accepted exactly as from IDLE.
- Latency: start sampled at edge E; busy is high for WIDTH+1 cycles; done is high in cycle E+WIDTH+2.
  - Latency is fixed and is independent of operand values, including the special cases.
- Start while busy (RUN/FIX): ignored, no queuing; operands and results are unaffected.
- Divide by zero:
  - quotient = all ones, remainder = src1 (original, unnegated), by_zero=1.
  - Applies to both signed and unsigned operation.
- Signed overflow (signed=1, src1 = 1<<(WIDTH-1), src2 = all ones):
  - quotient = src1, remainder = 0, by_zero=0.
- Signed results: the quotient truncates toward zero; the remainder takes the sign of the dividend, with |rem| < |divisor|.
- Output hold: quotient/remainder/by_zero change only in FIX; they hold across IDLE and through the next RUN.
- Reset mid-operation: abort at the next edge; all outputs return to reset values; no done pulse.
- Width rules:
  - The partial remainder carries one guard bit, WIDTH+1 wide.
  - Negation is two's-complement at WIDTH bits; the magnitude of the most-negative value is represented correctly as unsigned WIDTH.

Test Plan:
- Unsigned basic: signed=0, src1=100, src2=7, start at E -> done at E+34 (WIDTH=32); quotient=14, remainder=2, by_zero=0; busy high for cycles E+1..E+33.
- Signed mixed signs: src1=-100 (0xFFFFFF9C), src2=7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE); then src1=100, src2=-7 -> quotient=0xFFFFFFF2, remainder=2.
- Special cases:
  - Divide by zero: src1=0x12345678, src2=0, signed=0 and signed=1 -> quotient=0xFFFFFFFF, remainder=0x12345678, by_zero=1, same latency.
  - Overflow: signed, src1=0x80000000, src2=0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Unsigned extremes: src1=0xFFFFFFFF, src2=1 -> quotient=0xFFFFFFFF, remainder=0; src1=5, src2=0xFFFFFFFF -> quotient=0, remainder=5.
- Handshake:
  - start pulsed during RUN with different operands -> ignored, first result unchanged.
  - start asserted in the DONE cycle -> accepted; second done exactly 34 cycles later.
  - Results hold stable while idle for 10 cycles.
- Reset mid-operation: reset at E+10 -> next cycle busy=0, outputs zero, no done pulse; a fresh start afterwards computes 1000/10 -> quotient=100, remainder=0.

Source files
------------

// File: rtl/cpu_div_cell.sv
`default_nettype none
// ============================================================================
// Module      : cpu_div_cell
// Description : Iterative radix-2 non-restoring integer divider, one quotient
//               bit per cycle, signed/unsigned, with defined divide-by-zero
//               and signed-overflow results.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_div_cell #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A_div_start,
    input  logic             A_div_signed,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    output logic             A_div_busy,
    output logic             A_div_done,
    output logic [WIDTH-1:0] A_div_quotient,
    output logic [WIDTH-1:0] A_div_remainder,
    output logic             A_div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_pr;        // partial remainder with guard bit
    logic [WIDTH-1:0]   r_q;         // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]   r_d;         // divisor magnitude
    logic [WIDTH-1:0]   r_src1;      // original dividend for divide-by-zero
    logic               r_qneg;
    logic               r_rneg;
    logic               r_zero;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_by_zero;

    // Operand conditioning at start: magnitudes, result signs, special cases
    logic               w_src1_neg;
    logic               w_src2_neg;
    logic [WIDTH-1:0]   w_src1_mag;
    logic [WIDTH-1:0]   w_src2_mag;
    logic               w_ovf;

    assign w_src1_neg = A_div_signed & A_div_src1[WIDTH-1];
    assign w_src2_neg = A_div_signed & A_div_src2[WIDTH-1];
    assign w_src1_mag = w_src1_neg ? -A_div_src1 : A_div_src1;
    assign w_src2_mag = w_src2_neg ? -A_div_src2 : A_div_src2;
    assign w_ovf      = A_div_signed && (A_div_src1 == c_MIN_NEG) && (A_div_src2 == c_ONES);

    // One non-restoring step: shift in the next dividend bit, then subtract
    // when the partial remainder is non-negative, otherwise add. The shifted
    // value may wrap the guard bit, but the post-step result always fits.
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_pr_next;

    assign w_shift   = {r_pr[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_pr_next = r_pr[WIDTH] ? (w_shift + {1'b0, r_d}) : (w_shift - {1'b0, r_d});

    // Final restore step and sign correction; the corrected remainder lies in
    // [0, divisor) so WIDTH bits of modular arithmetic are enough.
    logic [WIDTH-1:0]   w_rem_mag;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_rem_mag = r_pr[WIDTH] ? (r_pr[WIDTH-1:0] + r_d) : r_pr[WIDTH-1:0];
    assign w_quo_fix = r_qneg ? -r_q : r_q;
    assign w_rem_fix = r_rneg ? -w_rem_mag : w_rem_mag;

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pr        <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_src1      <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_by_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (A_div_start) begin
                        r_q     <= w_src1_mag;
                        r_d     <= w_src2_mag;
                        r_src1  <= A_div_src1;
                        r_qneg  <= w_src1_neg ^ w_src2_neg;
                        r_rneg  <= w_src1_neg;
                        r_zero  <= (A_div_src2 == '0);
                        r_ovf   <= w_ovf;
                        r_pr    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_pr  <= w_pr_next;
                    r_q   <= {r_q[WIDTH-2:0], ~w_pr_next[WIDTH]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_zero) begin
                        r_quotient  <= c_ONES;
                        r_remainder <= r_src1;
                    end else if (r_ovf) begin
                        r_quotient  <= c_MIN_NEG;
                        r_remainder <= '0;
                    end else begin
                        r_quotient  <= w_quo_fix;
                        r_remainder <= w_rem_fix;
                    end
                    r_by_zero <= r_zero;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign A_div_busy      = r_busy;
    assign A_div_done      = r_done;
    assign A_div_quotient  = r_quotient;
    assign A_div_remainder = r_remainder;
    assign A_div_by_zero   = r_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_cpu_div_cell.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_div_cell
// Description : Directed self-checking bench for cpu_div_cell (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_div_cell;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sgn;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_div_cell #(
        .WIDTH (32),
        .CNT_W (6)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .A_div_start     (start),
        .A_div_signed    (sgn),
        .A_div_src1      (src1),
        .A_div_src2      (src2),
        .A_div_busy      (busy),
        .A_div_done      (done),
        .A_div_quotient  (quotient),
        .A_div_remainder (remainder),
        .A_div_by_zero   (by_zero)
    );

    // Single comparison point: counts every check, reports mismatches
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; returns #1 after that edge
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        sgn   = s;
        src1  = a;
        src2  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Wait (bounded) for done; optionally pulse a foreign start mid-run
    task automatic wait_done(input string tag, input int poke_at);
        int n;
        bit busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        while (n < 100) begin
            if (n == poke_at) begin
                start = 1'b1;
                sgn   = 1'b0;
                src1  = 32'd9;
                src2  = 32'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, n, 32'd33);
        check({tag, "_busy_window"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic [31:0] er, input logic ez);
        launch(s, a, b);
        wait_done(tag, -1);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_z"}, {31'd0, by_zero}, {31'd0, ez});
    endtask

    initial begin
        bit saw_done;
        reset = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        src1  = '0;
        src2  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_z", {31'd0, by_zero}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        op("u100_7",   1'b0, 32'd100,       32'd7,          32'd14,        32'd2,        1'b0);
        op("sn100_7",  1'b1, 32'hFFFFFF9C,  32'd7,          32'hFFFFFFF2,  32'hFFFFFFFE, 1'b0);
        op("s100_n7",  1'b1, 32'd100,       32'hFFFFFFF9,   32'hFFFFFFF2,  32'd2,        1'b0);
        op("sn100_n7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,   32'd14,        32'hFFFFFFFE, 1'b0);
        op("udiv0",    1'b0, 32'h12345678,  32'd0,          32'hFFFFFFFF,  32'h12345678, 1'b1);
        op("sdiv0",    1'b1, 32'h12345678,  32'd0,          32'hFFFFFFFF,  32'h12345678, 1'b1);
        op("sovf",     1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,  32'd0,        1'b0);
        op("umax_1",   1'b0, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,  32'd0,        1'b0);
        op("u5_max",   1'b0, 32'd5,         32'hFFFFFFFF,   32'd0,         32'd5,        1'b0);

        // Foreign start during RUN must be ignored
        launch(1'b0, 32'd200, 32'd9);
        wait_done("poke", 5);
        check("poke_q", quotient, 32'd22);
        check("poke_r", remainder, 32'd2);

        // Start in the DONE cycle is accepted, then results hold while idle
        op("done_start", 1'b0, 32'd50, 32'd8, 32'd6, 32'd2, 1'b0);
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("idle_no_done", {31'd0, saw_done}, 32'd0);
        check("hold_q", quotient, 32'd6);
        check("hold_r", remainder, 32'd2);

        // Reset mid-operation aborts with no done pulse
        launch(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_q", quotient, 32'd0);
        check("mid_rst_r", remainder, 32'd0);
        check("mid_rst_z", {31'd0, by_zero}, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("mid_rst_quiet", {31'd0, saw_done}, 32'd0);
        op("after_rst", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
